// File: rtl/jtdsp16_boot.sv
// Boot sequencer for jtdsp16: streams a byte image into the core's program ROM,
// holds the core in reset until the hold-off expires, then runs it with a level irq.
module jtdsp16_boot #(
  parameter int ROM_AW   = 13,
  parameter int LOAD_LEN = 8192,
  parameter int RST_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        dl_data,
  input  logic              dl_valid,
  output logic              dl_ready,
  output logic [ROM_AW-1:0] prog_addr,
  output logic [7:0]        prog_data,
  output logic              prog_we,
  output logic              dsp_rst,
  output logic              busy,
  output logic              done,
  input  logic              host_irq,
  input  logic              iack,
  output logic              irq
);
  // cnt carries one extra bit so a full 2^ROM_AW image never wraps back to zero.
  localparam int CW = ROM_AW + 1;
  localparam int HW = $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [HW-1:0]     hold, hold_nxt;
  logic [ROM_AW-1:0] addr_nxt;
  logic [7:0]        data_nxt;
  logic              we_nxt, irq_nxt, accept;

  assign accept = dl_valid & dl_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold;
    addr_nxt  = prog_addr;
    data_nxt  = prog_data;
    we_nxt    = 1'b0;
    irq_nxt   = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = LOAD;
        cnt_nxt   = '0;
      end
      LOAD: if (accept) begin
        we_nxt   = 1'b1;
        addr_nxt = cnt[ROM_AW-1:0];
        data_nxt = dl_data;
        cnt_nxt  = cnt + CW'(1);
        if (cnt == CW'(LOAD_LEN - 1)) begin
          state_nxt = HOLD;
          hold_nxt  = HW'(RST_HOLD);
        end
      end
      HOLD: begin
        // Leaving on hold==1 makes HOLD last exactly RST_HOLD cycles.
        hold_nxt = hold - HW'(1);
        if (hold == HW'(1)) state_nxt = RUN;
      end
      RUN: if (start) begin
        state_nxt = LOAD;
        cnt_nxt   = '0;
      end else begin
        irq_nxt = host_irq | (irq & ~iack);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hold      <= '0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_we   <= 1'b0;
      dl_ready  <= 1'b0;
      dsp_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hold      <= hold_nxt;
      prog_addr <= addr_nxt;
      prog_data <= data_nxt;
      prog_we   <= we_nxt;
      dl_ready  <= (state_nxt == LOAD);
      dsp_rst   <= (state_nxt != RUN);
      busy      <= (state_nxt == LOAD) || (state_nxt == HOLD);
      done      <= (state_nxt == RUN);
      irq       <= irq_nxt;
    end
  end
endmodule

// File: tb/tb_jtdsp16_boot.sv
// Randomized bench for jtdsp16_boot against an event/timestamp model of the boot flow.
module tb_jtdsp16_boot;
  localparam int AW = 13, LL = 512, RH = 16;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          start = 1'b0, dl_valid = 1'b0, host_irq = 1'b0, iack = 1'b0;
  logic [7:0]    dl_data = '0;
  logic          dl_ready, prog_we, dsp_rst, busy, done, irq;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;

  jtdsp16_boot #(.ROM_AW(AW), .LOAD_LEN(LL), .RST_HOLD(RH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dl_data(dl_data), .dl_valid(dl_valid),
    .dl_ready(dl_ready), .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we),
    .dsp_rst(dsp_rst), .busy(busy), .done(done), .host_irq(host_irq), .iack(iack), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: download progress is a byte count; the core runs from edge m_run_at onward
  // (last accept edge + RST_HOLD). e indexes the clock edges.
  bit            m_idle = 1'b1, m_load = 1'b0, m_irq = 1'b0, m_we = 1'b0;
  int            m_n = 0, m_run_at = 0, e = 0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_data = '0;

  function automatic bit m_run(input int at);
    return !m_idle && !m_load && at >= m_run_at;
  endfunction
  function automatic bit m_hold(input int at);
    return !m_idle && !m_load && at < m_run_at;
  endfunction

  task automatic chk_outs(input string pfx);
    chk({pfx, "ready"}, dl_ready, m_load);
    chk({pfx, "dsp_rst"}, dsp_rst, !m_run(e));
    chk({pfx, "busy"}, busy, m_load || m_hold(e));
    chk({pfx, "done"}, done, m_run(e));
    chk({pfx, "irq"}, irq, m_irq);
    chk({pfx, "we"}, prog_we, m_we);
    chk({pfx, "addr"}, prog_addr, m_addr);
    chk({pfx, "data"}, prog_data, m_data);
  endtask

  task automatic step(input bit s, input bit v, input logic [7:0] d, input bit hi, input bit ia);
    bit was_run, was_load;
    start = s; dl_valid = v; dl_data = d; host_irq = hi; iack = ia;
    @(posedge clk);
    was_run  = m_run(e - 1);
    was_load = m_load;
    m_we = was_load && v;
    if (m_we) begin
      m_addr = m_n[AW-1:0];
      m_data = d;
      m_n++;
      if (m_n == LL) begin
        m_load   = 1'b0;
        m_run_at = e + RH;
      end
    end
    if (s && (m_idle || was_run)) begin
      m_load = 1'b1; m_idle = 1'b0; m_n = 0; m_irq = 1'b0;
    end else if (was_run) m_irq = hi | (m_irq & ~ia);
    else m_irq = 1'b0;
    #1;
    chk_outs("");
    e++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    start = 1'b0; dl_valid = 1'b0; host_irq = 1'b0; iack = 1'b0;
    rst_n = 1'b0;
    m_idle = 1'b1; m_load = 1'b0; m_irq = 1'b0; m_we = 1'b0;
    m_addr = '0; m_data = '0; m_n = 0;
    #1;
    chk_outs("rst_");
    repeat (n) @(posedge clk);
    #1;
    chk_outs("rst_hold_");
    e += n;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode 0: continuous stream i&0xFF with ignored starts; 1: valid toggling; 2: random + reset at 300
  task automatic download(input int mode, input int cap);
    bit s, v, did_rst;
    logic [7:0] d;
    int k_done;
    did_rst = 1'b0; k_done = -1;
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int k = 1; k < cap; k++) begin
      if (mode == 2 && !did_rst && m_load && m_n == 300) begin
        do_reset(2);
        did_rst = 1'b1;
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        continue;
      end
      s = 1'b0; v = 1'b1; d = m_n[7:0];
      case (mode)
        0: s = (m_load && m_n == 100) || (m_hold(e - 1) && (m_run_at - e) == 5);
        1: begin v = k[0]; d = 8'($urandom); end
        default: begin v = ($urandom % 3) != 0; d = 8'($urandom); end
      endcase
      step(s, v, d, ($urandom % 5) == 0, ($urandom % 7) == 0);
      if (done) begin k_done = k; break; end
    end
    chk("reach_run", done, 1);
    if (mode == 0) chk("dl_time", k_done + 1, LL + RH + 1);
  endtask

  initial begin
    #1;
    do_reset(3);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    download(0, 3000);
    for (int j = 0; j < 40; j++) begin
      step(1'b0, 1'($urandom), 8'($urandom), j == 10 || j == 30, j == 20 || j == 30);
      if (j == 10) chk("irq_set", irq, 1);
      if (j == 20) chk("irq_ack", irq, 0);
      if (j == 30) chk("irq_both", irq, 1);
    end

    download(1, 3000);
    for (int j = 0; j < 60; j++)
      step(1'b0, 1'($urandom), 8'($urandom), ($urandom % 4) == 0, ($urandom % 3) == 0);

    download(2, 4000);
    for (int j = 0; j < 10; j++)
      step(1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
